// File: rtl/fetch_decode.sv
// fetch_decode: instruction fetch plus decode register feeding ctrl.
// Owns the PC, keeps at most one imem request in flight, latches the returned
// word (swapping in NOP_INST for non-32-bit encodings), and holds it under a
// valid/ready handshake. A redirect flushes the held word and refetches.
module fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        redir,
  input  logic [31:0] redir_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] inst,
  output logic [31:0] pc_out,
  output logic [4:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        illegal
);

  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        illegal_q, illegal_d;

  logic        word_legal;

  assign word_legal = (imem_rdata[1:0] == 2'b11);

  // Next-state: redirect outranks both the memory ack and downstream ready.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    pc_out_d  = pc_out_q;
    illegal_d = illegal_q;

    if (redir) begin
      pc_d    = redir_pc & ~32'h0000_0003;
      state_d = ST_REQ;
    end else begin
      unique case (state_q)
        ST_REQ: begin
          if (imem_ack) begin
            state_d  = ST_HOLD;
            pc_out_d = pc_q;
            if (word_legal) begin
              inst_d    = imem_rdata;
              illegal_d = 1'b0;
            end else begin
              inst_d    = NOP_INST;
              illegal_d = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (dec_ready) begin
            pc_d    = pc_q + 32'd4;
            state_d = ST_REQ;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  // State and decode registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_REQ;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      pc_out_q  <= RESET_PC;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      pc_out_q  <= pc_out_d;
      illegal_q <= illegal_d;
    end
  end

  // Request is suppressed during reset so memory never sees a fetch it must drop.
  always_comb begin
    imem_req  = (state_q == ST_REQ) && !rst;
    imem_addr = {pc_q[31:2], 2'b00};
    dec_valid = (state_q == ST_HOLD);
    inst      = inst_q;
    pc_out    = pc_out_q;
    illegal   = illegal_q;
    opcode    = inst_q[6:2];
    func3     = inst_q[14:12];
    func7     = inst_q[31:25];
    rd        = inst_q[11:7];
    rs1       = inst_q[19:15];
    rs2       = inst_q[24:20];
  end

endmodule

// File: tb/tb_fetch_decode.sv
// Testbench for fetch_decode: directed test-plan sequences followed by a
// randomized run, both checked against a transaction-level reference model.
module tb_fetch_decode;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        redir;
  logic [31:0] redir_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] inst;
  logic [31:0] pc_out;
  logic [4:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        illegal;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: the fetch PC, whether a word is held, and the held word.
  logic [31:0] m_pc;
  logic        m_held;
  logic [31:0] m_inst;
  logic [31:0] m_pc_out;
  logic        m_ill;

  fetch_decode #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .redir(redir), .redir_pc(redir_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .inst(inst), .pc_out(pc_out),
    .opcode(opcode), .func3(func3), .func7(func7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of the spec rules to the model, using the inputs the DUT saw.
  task automatic model_tick();
    if (rst) begin
      m_pc = RST_PC; m_held = 1'b0; m_inst = '0; m_pc_out = RST_PC; m_ill = 1'b0;
    end else if (redir) begin
      m_pc = {redir_pc[31:2], 2'b00};
      m_held = 1'b0;
    end else if (!m_held && imem_ack) begin
      m_held   = 1'b1;
      m_pc_out = m_pc;
      m_ill    = (imem_rdata[1:0] != 2'b11);
      m_inst   = m_ill ? NOP : imem_rdata;
    end else if (m_held && dec_ready) begin
      m_pc   = m_pc + 32'd4;
      m_held = 1'b0;
    end
  endtask

  task automatic compare_all();
    logic exp_req;
    exp_req = !m_held && !rst;
    check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    if (exp_req) check("imem_addr", imem_addr, {m_pc[31:2], 2'b00});
    check("dec_valid", {31'd0, dec_valid}, {31'd0, m_held});
    check("inst", inst, m_inst);
    check("pc_out", pc_out, m_pc_out);
    check("opcode", {27'd0, opcode}, {27'd0, m_inst[6:2]});
    check("func3", {29'd0, func3}, {29'd0, m_inst[14:12]});
    check("func7", {25'd0, func7}, {25'd0, m_inst[31:25]});
    check("rd", {27'd0, rd}, {27'd0, m_inst[11:7]});
    check("rs1", {27'd0, rs1}, {27'd0, m_inst[19:15]});
    check("rs2", {27'd0, rs2}, {27'd0, m_inst[24:20]});
    check("illegal", {31'd0, illegal}, {31'd0, m_ill});
  endtask

  // Called at a negedge: drive inputs, cross one posedge, compare at the next negedge.
  task automatic step(input logic r, input logic a, input logic [31:0] d,
                      input logic rdy, input logic rdr, input logic [31:0] rpc);
    rst = r; imem_ack = a; imem_rdata = d; dec_ready = rdy; redir = rdr; redir_pc = rpc;
    @(posedge clk);
    model_tick();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; dec_ready = 1'b0;
    redir = 1'b0; redir_pc = '0;
    m_pc = '0; m_held = 1'b0; m_inst = '0; m_pc_out = '0; m_ill = 1'b0;
    @(negedge clk);

    // Reset state
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 32'h0020_81B3, 1, 0, 0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, dec_valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_pc_out", pc_out, RST_PC);
    rst = 1'b0; imem_ack = 1'b0; dec_ready = 1'b0;
    #1;
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'd0);
    @(negedge clk);
    model_tick();

    // Zero-wait add x3,x1,x2 with ready
    step(0, 1, 32'h0020_81B3, 1, 0, 0);
    check("add_valid", {31'd0, dec_valid}, 32'd1);
    check("add_opcode", {27'd0, opcode}, 32'h0C);
    check("add_func3", {29'd0, func3}, 32'd0);
    check("add_func7", {25'd0, func7}, 32'd0);
    check("add_rd", {27'd0, rd}, 32'd3);
    check("add_rs1", {27'd0, rs1}, 32'd1);
    check("add_rs2", {27'd0, rs2}, 32'd2);
    check("add_pc_out", pc_out, 32'd0);
    step(0, 0, 0, 1, 0, 0);
    check("add_next_addr", imem_addr, 32'd4);
    check("add_next_req", {31'd0, imem_req}, 32'd1);

    // Backpressure with sub, from pc 0
    step(0, 0, 0, 0, 1, 32'h0);
    step(0, 1, 32'h4020_81B3, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 32'hFFFF_FFFF, 0, 0, 0);
      check("bp_func7", {25'd0, func7}, 32'h20);
      check("bp_req", {31'd0, imem_req}, 32'd0);
      check("bp_inst", inst, 32'h4020_81B3);
    end
    step(0, 0, 0, 1, 0, 0);
    check("bp_next_addr", imem_addr, 32'd4);

    // Redirect in HOLD beats dec_ready
    step(0, 1, 32'h0020_81B3, 0, 0, 0);
    step(0, 0, 0, 1, 1, 32'h0000_0103);
    check("rdh_valid", {31'd0, dec_valid}, 32'd0);
    check("rdh_addr", imem_addr, 32'h0000_0100);

    // Redirect coincident with ack
    step(0, 1, 32'h0020_81B3, 0, 1, 32'h0000_0200);
    check("rda_valid", {31'd0, dec_valid}, 32'd0);
    check("rda_addr", imem_addr, 32'h0000_0200);

    // Illegal word then legal word
    step(0, 1, 32'h0000_0000, 0, 0, 0);
    check("ill_inst", inst, 32'h0000_0013);
    check("ill_opcode", {27'd0, opcode}, 32'h04);
    check("ill_flag", {31'd0, illegal}, 32'd1);
    check("ill_pc_out", pc_out, 32'h0000_0200);
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 32'h0020_81B3, 0, 0, 0);
    check("legal_flag", {31'd0, illegal}, 32'd0);
    step(0, 0, 0, 1, 0, 0);

    // Reset during a 3-wait-state fetch at pc 8; ack arrives while rst is high
    step(0, 0, 0, 0, 1, 32'h0000_0008);
    step(0, 0, 0, 0, 0, 0);
    check("ws_addr", imem_addr, 32'd8);
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 32'h0020_81B3, 0, 0, 0);
    check("mid_rst_valid", {31'd0, dec_valid}, 32'd0);
    rst = 1'b0; imem_ack = 1'b0;
    #1;
    check("restart_addr", imem_addr, RST_PC);
    check("restart_req", {31'd0, imem_req}, 32'd1);
    @(negedge clk);
    model_tick();

    // PC wrap
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    step(0, 1, 32'h0020_81B3, 0, 0, 0);
    check("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
    step(0, 0, 0, 1, 0, 0);
    check("wrap_addr", imem_addr, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(3) != 0) w[1:0] = 2'b11;
      step(($urandom_range(99) == 0),
           ($urandom_range(2) == 0),
           w,
           ($urandom_range(1) == 0),
           ($urandom_range(15) == 0),
           $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
Name: fetch_decode

Overview:
- Instruction fetch and decode-register stage directly upstream of ctrl.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Latches the returned word and splits it into opcode[6:2], func3, func7, rd, rs1 and rs2 for ctrl, the regfile and imm_mux.
- Holds the decoded word under a valid/ready handshake until the core accepts it; branch/jump redirects flush it.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, substitute word for illegal encodings (addi x0,x0,0).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request
- imem_addr  out  32  word-aligned fetch address
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- imem_ack  in  1  memory returns imem_rdata this cycle
- redir  in  1  redirect/flush (taken branch, jal, jalr)
- redir_pc  in  32  redirect target
- dec_valid  out  1  decoded instruction held
- dec_ready  in  1  downstream accepts the held instruction
- inst  out  32  held instruction word
- pc_out  out  32  PC of held instruction
- opcode  out  5  inst[6:2], feeds ctrl
- func3  out  3  inst[14:12]
- func7  out  7  inst[31:25]
- rd  out  5  inst[11:7]
- rs1  out  5  inst[19:15]
- rs2  out  5  inst[24:20]
- illegal  out  1  held word had inst[1:0] != 2'b11

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = REQ, pc = RESET_PC.
  - dec_valid = 0, illegal = 0, inst = 0, and every field output = 0.
  - pc_out = RESET_PC.
  - imem_req = 0 while rst is high.
- States: REQ and HOLD.
- REQ:
  - imem_req = 1 and imem_addr = {pc[31:2], 2'b00}.
  - imem_addr stays stable until imem_ack.
  - On imem_ack without redir: latch the word and pc_out = pc; go to HOLD.
  - The first cycle of HOLD has dec_valid = 1. Latency from ack to valid is 1 cycle.
- HOLD:
  - imem_req = 0 and dec_valid = 1. All outputs are stable while dec_ready = 0.
  - On dec_ready = 1: pc <= pc + 4 (wraps modulo 2^32); go to REQ.
  - The next fetch is issued the cycle after acceptance.
- Redirect:
  - redir = 1 in any state: pc <= {redir_pc[31:2], 2'b00}, go to REQ, dec_valid <= 0.
  - A simultaneous imem_ack word is discarded.
  - A held instruction is dropped even if dec_ready = 1, so redir has priority over dec_ready and ack.
  - redir and rst together: rst wins.
- Decode:
  - Fields are taken from the latched word.
  - If imem_rdata[1:0] != 2'b11: inst = NOP_INST, fields are decoded from NOP_INST (opcode 5'b00100, the rest 0), and illegal = 1.
  - illegal is cleared when the next word is latched.
- Memory interface: one request outstanding. imem_ack is ignored outside REQ.
- Reset mid-fetch: a pending request is abandoned; memory shares rst and drops it. Fetch restarts at RESET_PC the cycle after rst falls.
- Throughput:
  - Maximum one instruction per 2 cycles with zero-wait memory: REQ+ack, then HOLD+ready.
  - Per-instruction latency is wait states + 2.

Test Plan:
- Reset, then zero-wait memory returning 32'h0020_81B3 (add x3,x1,x2) with dec_ready=1:
  - imem_addr=0 on the first cycle.
  - dec_valid the next cycle with opcode=01100, func3=000, func7=0000000, rd=3, rs1=1, rs2=2, pc_out=0.
  - The next request goes to addr 4.
- Backpressure: hold dec_ready=0 for 4 cycles with word 32'h4020_81B3 (sub):
  - Outputs are unchanged, func7=0100000, imem_req=0 throughout.
  - Raising dec_ready gives fetch addr 4 the following cycle.
- Redirect in HOLD with dec_ready=1 and redir_pc=32'h0000_0103: instruction dropped, dec_valid=0, next imem_addr=32'h0000_0100.
- Redirect coincident with imem_ack: the word is discarded, no dec_valid, and the next request goes to the redirect target.
- Illegal word 32'h0000_0000: inst=32'h0000_0013, opcode=00100, illegal=1.
  - Next legal word: illegal=0.
- rst asserted during a 3-wait-state fetch at pc=8: the late ack is ignored and the fetch restarts at RESET_PC. Repeat with pc=32'hFFFF_FFFC accepted, then the next fetch is at addr 0 (wrap).
